radar_pulse_sequencer: RTL and testbench

RADAR_PULSE_SEQUENCER -- requirements
Module: radar_pulse_sequencer

---
 rtl/radar_pulse_sequencer.sv | 157 +++++++++++++++
 tb/tb_radar_pulse_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radar_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : radar_pulse_sequencer
// Brief    : Sequences chirp init/trigger and ADC capture windows for N pulses.
// Revision : 1.0
// ============================================================================
module radar_pulse_sequencer #(
  parameter int CNT_WIDTH     = 32,
  parameter int READY_TIMEOUT = 4096
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [15:0]          cfg_num_pulses,
  input  logic [CNT_WIDTH-1:0] cfg_pulse_period,
  input  logic [15:0]          cfg_adc_delay,
  input  logic [CNT_WIDTH-1:0] cfg_adc_samples,
  input  logic                 chirp_ready,
  input  logic                 chirp_done,
  output logic                 chirp_init,
  output logic                 chirp_enable,
  output logic                 adc_enable,
  output logic                 busy,
  output logic                 seq_done,
  output logic                 timeout_err,
  output logic [15:0]          pulse_count
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INIT       = 3'd1,
    S_WAIT_READY = 3'd2,
    S_ARM        = 3'd3,
    S_DELAY      = 3'd4,
    S_CAPTURE    = 3'd5,
    S_HOLDOFF    = 3'd6,
    S_DONE       = 3'd7
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_ready_last = CNT_WIDTH'(READY_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_next;
  logic [15:0]          r_cfg_num;
  logic [15:0]          r_cfg_delay;
  logic [15:0]          r_pulse_count;
  logic [CNT_WIDTH-1:0] r_cfg_period;
  logic [CNT_WIDTH-1:0] r_cfg_samples;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_period_cnt;
  logic                 r_done_seen;
  logic                 r_timeout_err;

  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic [CNT_WIDTH-1:0] w_delay_ext;
  logic                 w_cfg_empty;
  logic                 w_period_met;
  logic                 w_last_pulse;
  logic                 w_timeout;
  logic                 w_pulse_end;
  logic                 w_run;

  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_delay_ext  = CNT_WIDTH'(r_cfg_delay);
  assign w_cfg_empty  = (cfg_num_pulses == '0) || (cfg_adc_samples == '0);
  // Extra MSB keeps a zero period and the saturated counter from wrapping.
  assign w_period_met = ({1'b0, r_period_cnt} + 1'b1) >= {1'b0, r_cfg_period};
  assign w_last_pulse = (r_pulse_count + 16'd1) == r_cfg_num;
  assign w_run        = ~abort;

  always_comb begin
    w_next      = r_state;
    w_timeout   = 1'b0;
    w_pulse_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = w_cfg_empty ? S_DONE : S_INIT;
      end
      S_INIT:       w_next = S_WAIT_READY;
      S_WAIT_READY: begin
        if (chirp_ready) begin
          w_next = S_ARM;
        end else if (r_cnt == c_ready_last) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
      end
      S_ARM:        w_next = (r_cfg_delay == '0) ? S_CAPTURE : S_DELAY;
      S_DELAY: begin
        if (w_cnt_inc == w_delay_ext) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (w_cnt_inc == r_cfg_samples) w_next = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (w_period_met && r_done_seen) begin
          w_pulse_end = 1'b1;
          w_next      = w_last_pulse ? S_DONE : S_ARM;
        end
      end
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_next      = S_IDLE;
      w_timeout   = 1'b0;
      w_pulse_end = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_cfg_num     <= '0;
      r_cfg_delay   <= '0;
      r_cfg_period  <= '0;
      r_cfg_samples <= '0;
      r_pulse_count <= '0;
      r_cnt         <= '0;
      r_period_cnt  <= '0;
      r_done_seen   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : w_cnt_inc;
      if ((r_state == S_IDLE) && start) begin
        r_cfg_num     <= cfg_num_pulses;
        r_cfg_delay   <= cfg_adc_delay;
        r_cfg_period  <= cfg_pulse_period;
        r_cfg_samples <= cfg_adc_samples;
        r_pulse_count <= '0;
        r_timeout_err <= 1'b0;
      end
      if (w_timeout)   r_timeout_err <= 1'b1;
      if (w_pulse_end) r_pulse_count <= r_pulse_count + 16'd1;
      // Counter reads 0 during ARM itself, so it is loaded with 1 for the next cycle.
      if (r_state == S_ARM) begin
        r_period_cnt <= CNT_WIDTH'(1);
        r_done_seen  <= chirp_done;
      end else begin
        if (r_period_cnt != '1) r_period_cnt <= r_period_cnt + 1'b1;
        r_done_seen <= r_done_seen | chirp_done;
      end
    end
  end

  assign chirp_init   = (r_state == S_INIT)    && w_run;
  assign chirp_enable = (r_state == S_ARM)     && w_run;
  assign adc_enable   = (r_state == S_CAPTURE) && w_run;
  assign seq_done     = (r_state == S_DONE)    && w_run;
  assign busy         = (r_state != S_IDLE);
  assign timeout_err  = r_timeout_err;
  assign pulse_count  = r_pulse_count;

endmodule
`default_nettype wire

// File: tb/tb_radar_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_radar_pulse_sequencer
// Brief    : Schedule-based reference model and directed tests for the sequencer.
// Revision : 1.0
// ============================================================================
module tb_radar_pulse_sequencer;

  localparam int CW   = 32;
  localparam int T    = 4096;
  localparam int MAXC = 6000;

  logic          aclk;
  logic          aresetn;
  logic          start;
  logic          abort;
  logic [15:0]   cfg_num_pulses;
  logic [CW-1:0] cfg_pulse_period;
  logic [15:0]   cfg_adc_delay;
  logic [CW-1:0] cfg_adc_samples;
  logic          chirp_ready;
  logic          chirp_done;
  logic          chirp_init;
  logic          chirp_enable;
  logic          adc_enable;
  logic          busy;
  logic          seq_done;
  logic          timeout_err;
  logic [15:0]   pulse_count;

  radar_pulse_sequencer #(
    .CNT_WIDTH     (CW),
    .READY_TIMEOUT (T)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .start            (start),
    .abort            (abort),
    .cfg_num_pulses   (cfg_num_pulses),
    .cfg_pulse_period (cfg_pulse_period),
    .cfg_adc_delay    (cfg_adc_delay),
    .cfg_adc_samples  (cfg_adc_samples),
    .chirp_ready      (chirp_ready),
    .chirp_done       (chirp_done),
    .chirp_init       (chirp_init),
    .chirp_enable     (chirp_enable),
    .adc_enable       (adc_enable),
    .busy             (busy),
    .seq_done         (seq_done),
    .timeout_err      (timeout_err),
    .pulse_count      (pulse_count)
  );

  // Expected output timeline, indexed by cycle number.
  bit          e_init [MAXC];
  bit          e_en   [MAXC];
  bit          e_adc  [MAXC];
  bit          e_busy [MAXC];
  bit          e_done [MAXC];
  bit          e_terr [MAXC];
  bit          drv_cd [MAXC];
  logic [15:0] e_cnt  [MAXC];

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  int en_q[$];
  int adc_q[$];
  int adc_len_q[$];
  int done_cnt;
  int init_cnt;
  int adc_rise;
  bit adc_prev;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial forever begin
    @(posedge aclk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge aclk);
    #1;
    chirp_done = (cyc < MAXC) ? drv_cd[cyc] : 1'b0;
  end

  task automatic chk(input string nm, input int got, input int exp_v);
    n_checks = n_checks + 1;
    if (got != exp_v) begin
      n_errors = n_errors + 1;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp_v);
    end
  endtask

  initial forever begin
    @(negedge aclk);
    if (chk_en && (cyc < MAXC)) begin
      chk("chirp_init",   int'(chirp_init),   int'(e_init[cyc]));
      chk("chirp_enable", int'(chirp_enable), int'(e_en[cyc]));
      chk("adc_enable",   int'(adc_enable),   int'(e_adc[cyc]));
      chk("busy",         int'(busy),         int'(e_busy[cyc]));
      chk("seq_done",     int'(seq_done),     int'(e_done[cyc]));
      chk("timeout_err",  int'(timeout_err),  int'(e_terr[cyc]));
      chk("pulse_count",  int'(pulse_count),  int'(e_cnt[cyc]));
    end
    if (chirp_enable) en_q.push_back(cyc);
    if (chirp_init) init_cnt = init_cnt + 1;
    if (seq_done) done_cnt = done_cnt + 1;
    if (adc_enable && !adc_prev) begin
      adc_rise = cyc;
      adc_q.push_back(cyc);
    end
    if (!adc_enable && adc_prev) adc_len_q.push_back(cyc - adc_rise);
    adc_prev = adc_enable;
  end

  task automatic clear_from(input int k0, input logic [15:0] cnt, input bit terr);
    for (int k = k0; k < MAXC; k++) begin
      e_init[k] = 1'b0;
      e_en[k]   = 1'b0;
      e_adc[k]  = 1'b0;
      e_busy[k] = 1'b0;
      e_done[k] = 1'b0;
      e_terr[k] = terr;
      e_cnt[k]  = cnt;
      drv_cd[k] = 1'b0;
    end
  endtask

  // Builds the expected timeline from pulse arithmetic; start is high during cycle c.
  task automatic plan_seq(input int c, input int num, input int per, input int dl,
                          input int smp, input int dly, input bit rdy, input int ab);
    int a;
    int h0;
    int ex;
    logic [15:0] held;
    clear_from(c + 1, 16'd0, 1'b0);
    e_busy[c+1] = 1'b1;
    if (num == 0 || smp == 0) begin
      e_done[c+1] = 1'b1;
    end else begin
      e_init[c+1] = 1'b1;
      if (!rdy) begin
        for (int k = c + 2; k <= c + 1 + T; k++) e_busy[k] = 1'b1;
        for (int k = c + 2 + T; k < MAXC; k++) e_terr[k] = 1'b1;
      end else begin
        e_busy[c+2] = 1'b1;
        a = c + 3;
        for (int p = 1; p <= num; p++) begin
          e_en[a] = 1'b1;
          drv_cd[a+dly] = 1'b1;
          for (int k = a + 1 + dl; k <= a + dl + smp; k++) e_adc[k] = 1'b1;
          h0 = a + 1 + dl + smp;
          ex = h0;
          if (a + per - 1 > ex) ex = a + per - 1;
          if (a + dly + 1 > ex) ex = a + dly + 1;
          for (int k = a; k <= ex; k++) e_busy[k] = 1'b1;
          for (int k = ex + 1; k < MAXC; k++) e_cnt[k] = 16'(p);
          a = ex + 1;
        end
        e_busy[a] = 1'b1;
        e_done[a] = 1'b1;
      end
    end
    if (ab > 0) begin
      held = e_cnt[ab];
      e_init[ab] = 1'b0;
      e_en[ab]   = 1'b0;
      e_adc[ab]  = 1'b0;
      e_done[ab] = 1'b0;
      clear_from(ab + 1, held, 1'b0);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic clear_logs;
    en_q.delete();
    adc_q.delete();
    adc_len_q.delete();
    done_cnt = 0;
    init_cnt = 0;
  endtask

  task automatic run_seq(input int num, input int per, input int dl, input int smp,
                         input int dly, input bit rdy, input int ab_rel, output int c0);
    cfg_num_pulses   = 16'(num);
    cfg_pulse_period = CW'(per);
    cfg_adc_delay    = 16'(dl);
    cfg_adc_samples  = CW'(smp);
    chirp_ready      = rdy;
    clear_logs();
    c0 = cyc;
    plan_seq(c0, num, per, dl, smp, dly, rdy, (ab_rel > 0) ? c0 + ab_rel : 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    int c;
    aresetn          = 1'b0;
    start            = 1'b0;
    abort            = 1'b0;
    chirp_ready      = 1'b1;
    chirp_done       = 1'b0;
    cfg_num_pulses   = '0;
    cfg_pulse_period = '0;
    cfg_adc_delay    = '0;
    cfg_adc_samples  = '0;
    adc_prev         = 1'b0;
    adc_rise         = 0;
    clear_from(0, 16'd0, 1'b0);
    tick(1);
    chk_en = 1'b1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulse_count", int'(pulse_count), 0);
    chk("reset_timeout_err", int'(timeout_err), 0);
    tick(2);
    aresetn = 1'b1;
    tick(2);

    // Two pulses, period 20, delay 3, 5 samples.
    run_seq(2, 20, 3, 5, 2, 1'b1, 0, c);
    tick(50);
    chk("t1_num_chirps", en_q.size(), 2);
    chk("t1_chirp_spacing", en_q[1] - en_q[0], 20);
    chk("t1_adc_offset", adc_q[0] - en_q[0], 4);
    chk("t1_adc_len", adc_len_q[0], 5);
    chk("t1_seq_done_cnt", done_cnt, 1);
    chk("t1_pulse_count", int'(pulse_count), 2);

    // Period shorter than pulse body stretches to 12 cycles.
    run_seq(3, 4, 2, 8, 2, 1'b1, 0, c);
    tick(50);
    chk("t2_spacing_a", en_q[1] - en_q[0], 12);
    chk("t2_spacing_b", en_q[2] - en_q[1], 12);
    chk("t2_adc_spacing", adc_q[1] - adc_q[0], 12);
    chk("t2_adc_len", adc_len_q[0], 8);
    chk("t2_pulse_count", int'(pulse_count), 3);

    // Zero delay and chirp_done in the ARM cycle itself.
    run_seq(2, 1, 0, 3, 0, 1'b1, 0, c);
    tick(30);
    chk("t3_spacing", en_q[1] - en_q[0], 5);
    chk("t3_adc_offset", adc_q[0] - en_q[0], 1);
    chk("t3_seq_done_cnt", done_cnt, 1);

    // Late chirp_done holds HOLDOFF; a mid-sequence start with new cfg is ignored.
    run_seq(2, 6, 1, 2, 12, 1'b1, 0, c);
    tick(5);
    cfg_num_pulses   = 16'd9;
    cfg_pulse_period = CW'(2);
    cfg_adc_samples  = CW'(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(40);
    chk("t4_num_chirps", en_q.size(), 2);
    chk("t4_spacing", en_q[1] - en_q[0], 14);
    chk("t4_pulse_count", int'(pulse_count), 2);

    // chirp_ready never rises.
    run_seq(1, 20, 3, 5, 2, 1'b0, 0, c);
    tick(T);
    chk("t5_busy_last_wait", int'(busy), 1);
    tick(1);
    chk("t5_busy_after_timeout", int'(busy), 0);
    chk("t5_timeout_err", int'(timeout_err), 1);
    tick(3);
    chk("t5_no_seq_done", done_cnt, 0);

    // Zero pulses: straight to DONE, clears timeout_err.
    run_seq(0, 20, 3, 5, 2, 1'b1, 0, c);
    chk("t6_seq_done_next", int'(seq_done), 1);
    tick(3);
    chk("t6_no_init", init_cnt, 0);
    chk("t6_no_adc", adc_q.size(), 0);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_timeout_cleared", int'(timeout_err), 0);

    // Zero samples behaves the same way.
    run_seq(2, 20, 3, 0, 2, 1'b1, 0, c);
    tick(4);
    chk("t7_no_init", init_cnt, 0);
    chk("t7_done_cnt", done_cnt, 1);

    // Abort in the third CAPTURE cycle of pulse 2.
    run_seq(3, 20, 3, 5, 2, 1'b1, 29, c);
    tick(28);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t8_adc_after_abort", int'(adc_enable), 0);
    chk("t8_busy_after_abort", int'(busy), 0);
    tick(30);
    chk("t8_pulse_count", int'(pulse_count), 1);
    chk("t8_no_seq_done", done_cnt, 0);

    // Reset during HOLDOFF of pulse 2.
    run_seq(2, 20, 3, 5, 2, 1'b1, 0, c);
    tick(34);
    chk("t9_pre_reset_count", int'(pulse_count), 1);
    aresetn = 1'b0;
    clear_from(cyc + 1, 16'd0, 1'b0);
    tick(1);
    aresetn = 1'b1;
    chk("t9_reset_busy", int'(busy), 0);
    chk("t9_reset_pulse_count", int'(pulse_count), 0);
    tick(30);
    chk("t9_no_seq_done", done_cnt, 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
